// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory/peripheral bus arbiter:
// sequencer state encoding, port indices and default bus widths.
package mem_bus_arbiter_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 11;

   localparam logic PORT_0 = 1'b0;
   localparam logic PORT_1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-requester round-robin pick: on a tie the port that was
// not served last wins, otherwise the single requester is granted.
module rr_arbiter2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt
);

   always_comb begin
      gnt = PORT_0;
      case (req)
         2'b01:   gnt = PORT_0;
         2'b10:   gnt = PORT_1;
         2'b11:   gnt = ~last;
         default: gnt = PORT_0;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data
// memory / peripheral bus; every output is driven straight from a flop.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_0,
   input  logic                  i_wr_0,
   input  logic [ADDR_WIDTH-1:0] i_addr_0,
   input  logic [DATA_WIDTH-1:0] i_data_0,
   output logic                  o_ack_0,
   output logic [DATA_WIDTH-1:0] o_rdata_0,
   input  logic                  i_req_1,
   input  logic                  i_wr_1,
   input  logic [ADDR_WIDTH-1:0] i_addr_1,
   input  logic [DATA_WIDTH-1:0] i_data_1,
   output logic                  o_ack_1,
   output logic [DATA_WIDTH-1:0] o_rdata_1,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic                  o_mem_wr,
   output logic                  o_mem_rd,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic                  o_owner,
   output logic                  o_busy
);

   localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  owner_q, owner_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mem_wr_q, mem_wr_d;
   logic                  mem_rd_q, mem_rd_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  busy_q, busy_d;
   logic                  gnt;

   rr_arbiter2 u_rr_arbiter2 (
      .req  ({i_req_1, i_req_0}),
      .last (last_q),
      .gnt  (gnt)
   );

   // Strobes, acks and busy are computed one state ahead so that they
   // appear registered in exactly the state they belong to.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mem_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (i_req_0 || i_req_1) begin
               state_d = ST_ISSUE;
               owner_d = gnt;
               last_d  = gnt;
               busy_d  = 1'b1;
               if (gnt == PORT_1) begin
                  wr_d    = i_wr_1;
                  addr_d  = i_addr_1;
                  wdata_d = i_data_1;
               end else begin
                  wr_d    = i_wr_0;
                  addr_d  = i_addr_0;
                  wdata_d = i_data_0;
               end
               mem_wr_d = wr_d;
               mem_rd_d = ~wr_d;
            end
         end

         ST_ISSUE: begin
            if (wr_q) begin
               state_d = ST_DONE;
               ack0_d  = (owner_q == PORT_0);
               ack1_d  = (owner_q == PORT_1);
            end else begin
               state_d  = ST_WAIT;
               mem_rd_d = 1'b1;
               cnt_d    = CNT_W'(RD_LATENCY - 1);
            end
         end

         // The read strobe stays up until the last wait cycle, where the
         // memory data is valid and is captured for the owning port only.
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               ack0_d  = (owner_q == PORT_0);
               ack1_d  = (owner_q == PORT_1);
               if (owner_q == PORT_1) begin
                  rdata1_d = i_mem_data;
               end else begin
                  rdata0_d = i_mem_data;
               end
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               mem_rd_d = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         last_q   <= PORT_1;
         owner_q  <= PORT_0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mem_wr_q <= mem_wr_d;
         mem_rd_q <= mem_rd_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
      end
   end

   assign o_ack_0    = ack0_q;
   assign o_ack_1    = ack1_q;
   assign o_rdata_0  = rdata0_q;
   assign o_rdata_1  = rdata1_q;
   assign o_mem_addr = addr_q;
   assign o_mem_data = wdata_q;
   assign o_mem_wr   = mem_wr_q;
   assign o_mem_rd   = mem_rd_q;
   assign o_owner    = owner_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected acks into a
// scoreboard queue that a negedge monitor pops and compares.
module tb_mem_bus_arbiter;

   localparam int DW         = 16;
   localparam int AW         = 11;
   localparam int RD_LATENCY = 1;

   typedef struct {
      logic          port;
      logic          rd;
      logic [DW-1:0] data;
   } sb_entry_t;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_req_0 = 1'b0, i_wr_0 = 1'b0;
   logic [AW-1:0] i_addr_0 = '0;
   logic [DW-1:0] i_data_0 = '0;
   logic          i_req_1 = 1'b0, i_wr_1 = 1'b0;
   logic [AW-1:0] i_addr_1 = '0;
   logic [DW-1:0] i_data_1 = '0;
   logic          o_ack_0, o_ack_1, o_mem_wr, o_mem_rd, o_owner, o_busy;
   logic [DW-1:0] o_rdata_0, o_rdata_1, o_mem_data;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] i_mem_data = '0;

   sb_entry_t     sb[$];
   sb_entry_t     mon_e;
   logic [DW-1:0] exp_rdata0 = '0;
   logic [DW-1:0] exp_rdata1 = '0;
   int            checks = 0;
   int            fails  = 0;
   logic [DW-1:0] ram [0:1023];

   mem_bus_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (RD_LATENCY)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_req_0    (i_req_0),
      .i_wr_0     (i_wr_0),
      .i_addr_0   (i_addr_0),
      .i_data_0   (i_data_0),
      .o_ack_0    (o_ack_0),
      .o_rdata_0  (o_rdata_0),
      .i_req_1    (i_req_1),
      .i_wr_1     (i_wr_1),
      .i_addr_1   (i_addr_1),
      .i_data_1   (i_data_1),
      .o_ack_1    (o_ack_1),
      .o_rdata_1  (o_rdata_1),
      .o_mem_addr (o_mem_addr),
      .o_mem_data (o_mem_data),
      .o_mem_wr   (o_mem_wr),
      .o_mem_rd   (o_mem_rd),
      .i_mem_data (i_mem_data),
      .o_owner    (o_owner),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // One-cycle-latency RAM; the peripheral half always answers 0xBEEF.
   always @(posedge i_clk) begin
      if (o_mem_wr && !o_mem_addr[10]) ram[o_mem_addr[9:0]] <= o_mem_data;
      if (o_mem_rd) i_mem_data <= o_mem_addr[10] ? 16'hBEEF : ram[o_mem_addr[9:0]];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic setReq(input logic port, input logic req, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (port) begin
         i_req_1 = req; i_wr_1 = wr; i_addr_1 = addr; i_data_1 = data;
      end else begin
         i_req_0 = req; i_wr_0 = wr; i_addr_0 = addr; i_data_0 = data;
      end
   endtask

   // Must be entered at a negedge with the DUT idle; returns one cycle after DONE.
   task automatic applyStimulus(input logic port, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [DW-1:0] exp_rdata);
      sb_entry_t e;
      e.port = port; e.rd = !wr; e.data = exp_rdata;
      sb.push_back(e);
      setReq(port, 1'b1, wr, addr, data);
      checkOutput("idle_busy", o_busy, 0);
      @(negedge i_clk);
      checkOutput("issue_wr", o_mem_wr, wr);
      checkOutput("issue_rd", o_mem_rd, !wr);
      checkOutput("issue_addr", o_mem_addr, addr);
      if (wr) checkOutput("issue_data", o_mem_data, data);
      checkOutput("issue_owner", o_owner, port);
      checkOutput("issue_busy", o_busy, 1);
      setReq(port, 1'b0, !wr, 11'h7FF, 16'hDEAD);
      if (!wr) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            @(negedge i_clk);
            checkOutput("wait_rd", o_mem_rd, 1);
            checkOutput("wait_addr", o_mem_addr, addr);
         end
      end
      @(negedge i_clk);
      checkOutput("done_ack", port ? o_ack_1 : o_ack_0, 1);
      checkOutput("done_strobes", {o_mem_wr, o_mem_rd}, 0);
      checkOutput("done_addr_held", o_mem_addr, addr);
      @(negedge i_clk);
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         checkOutput("strobe_exclusive", o_mem_wr & o_mem_rd, 0);
         if (o_ack_0 || o_ack_1) begin
            checkOutput("single_ack", o_ack_0 & o_ack_1, 0);
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_ack: got ack0=%b ack1=%b, expected none at %0t",
                        o_ack_0, o_ack_1, $time);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("ack_port", o_ack_1, mon_e.port);
               if (mon_e.rd) begin
                  if (mon_e.port) exp_rdata1 = mon_e.data;
                  else exp_rdata0 = mon_e.data;
               end
               checkOutput("rdata_0", o_rdata_0, exp_rdata0);
               checkOutput("rdata_1", o_rdata_1, exp_rdata1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n0, n1, cyc;
      sb_entry_t e;

      @(negedge i_clk);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_acks", {o_ack_0, o_ack_1}, 0);
      checkOutput("rst_strobes", {o_mem_wr, o_mem_rd}, 0);
      checkOutput("rst_addr", o_mem_addr, 0);
      checkOutput("rst_data", o_mem_data, 0);
      checkOutput("rst_rdata", {o_rdata_0, o_rdata_1}, 0);
      checkOutput("rst_owner", o_owner, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      applyStimulus(1'b0, 1'b1, 11'h005, 16'h1234, 16'h0000);
      applyStimulus(1'b1, 1'b0, 11'h005, 16'h0000, 16'h1234);
      applyStimulus(1'b0, 1'b0, 11'h400, 16'h0000, 16'hBEEF);

      // Port 1 read cut off by an asynchronous reset during WAIT.
      e.port = 1'b1; e.rd = 1'b1; e.data = 16'h1234;
      sb.push_back(e);
      setReq(1'b1, 1'b1, 1'b0, 11'h005, 16'h0000);
      @(negedge i_clk);
      checkOutput("abort_issue_rd", o_mem_rd, 1);
      setReq(1'b1, 1'b0, 1'b0, 11'h000, 16'h0000);
      @(negedge i_clk);
      checkOutput("abort_wait_rd", o_mem_rd, 1);
      checkOutput("abort_wait_busy", o_busy, 1);
      #1 i_rst = 1'b1;
      #1;
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_rd", o_mem_rd, 0);
      checkOutput("abort_addr", o_mem_addr, 0);
      checkOutput("abort_ack1", o_ack_1, 0);
      checkOutput("abort_rdata", {o_rdata_0, o_rdata_1}, 0);
      sb.delete();
      exp_rdata0 = '0;
      exp_rdata1 = '0;
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      checkOutput("post_abort_busy", o_busy, 0);
      checkOutput("post_abort_ack1", o_ack_1, 0);
      applyStimulus(1'b0, 1'b1, 11'h007, 16'h5555, 16'h0000);

      // Fresh reset, then both ports saturate: grants must alternate 0,1,0,1...
      #2 i_rst = 1'b1;
      #2 i_rst = 1'b0;
      exp_rdata0 = '0;
      exp_rdata1 = '0;
      @(negedge i_clk);
      for (int k = 0; k < 4; k++) begin
         e.port = 1'b0; e.rd = 1'b0; e.data = 16'h0000; sb.push_back(e);
         e.port = 1'b1; e.rd = 1'b1; e.data = 16'hA5A5; sb.push_back(e);
      end
      setReq(1'b0, 1'b1, 1'b1, 11'h010, 16'hA5A5);
      setReq(1'b1, 1'b1, 1'b0, 11'h010, 16'h0000);
      n0 = 0; n1 = 0; cyc = 0;
      while ((n0 < 4 || n1 < 4) && cyc < 100) begin
         @(negedge i_clk);
         cyc++;
         if (o_ack_0) begin n0++; if (n0 == 4) i_req_0 = 1'b0; end
         if (o_ack_1) begin n1++; if (n1 == 4) i_req_1 = 1'b0; end
      end
      checkOutput("sat_ack0_count", n0, 4);
      checkOutput("sat_ack1_count", n1, 4);

      repeat (4) @(negedge i_clk);
      checkOutput("final_busy", o_busy, 0);
      checkOutput("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
